ipg_rx: RTL and testbench

Receive-side counterpart of the IPG transmit mux. Sits between the 64b/66b block-sync/descrambler output and the PCS decoder. It extracts IPG request blocks (block type 0x1a) and IPG response blocks (block type 0x1f) carried in inter-frame gaps into two first-word-fall-through queues. Each extracted block is replaced by a standard idle control block, so the downstream decoder and MAC see a legal 802.3 stream.

---
 rtl/ipg_rx_if.sv | 33 +++
 rtl/ipg_rx.sv | 173 +++++++++++++++++
 tb/tb_ipg_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ipg_rx_if.sv
// Stream, extraction-queue and statistics signals of the IPG receive block.
// The slave modport is the ipg_rx view; master is the surrounding logic.
interface ipg_rx_if #(
    parameter int CNT_W = 16
);
    logic [63:0]      encoded_rx_data;
    logic [1:0]       encoded_rx_hdr;
    logic [63:0]      proced_encoded_rx_data;
    logic [1:0]       proced_encoded_rx_hdr;
    logic [63:0]      rx_req_chunk;
    logic             rx_req_valid;
    logic             rx_req_ready;
    logic [63:0]      rx_resp_chunk;
    logic             rx_resp_valid;
    logic             rx_resp_ready;
    logic [CNT_W-1:0] req_drop_cnt;
    logic [CNT_W-1:0] resp_drop_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport slave (
        input  encoded_rx_data, encoded_rx_hdr, rx_req_ready, rx_resp_ready,
        output proced_encoded_rx_data, proced_encoded_rx_hdr,
               rx_req_chunk, rx_req_valid, rx_resp_chunk, rx_resp_valid,
               req_drop_cnt, resp_drop_cnt, err_cnt
    );

    modport master (
        output encoded_rx_data, encoded_rx_hdr, rx_req_ready, rx_resp_ready,
        input  proced_encoded_rx_data, proced_encoded_rx_hdr,
               rx_req_chunk, rx_req_valid, rx_resp_chunk, rx_resp_valid,
               req_drop_cnt, resp_drop_cnt, err_cnt
    );
endinterface

// File: rtl/ipg_rx.sv
// IPG receive extractor: pulls IPG request (0x1a) and response (0x1f) control
// blocks out of inter-frame gaps into two FWFT queues and replaces each one
// with an idle control block so the decoder sees a legal stream.
module ipg_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic     clk,
    input  logic     reset,
    ipg_rx_if.slave  bus
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [63:0]     IDLE_BLK = 64'h000000000000001e;
    localparam logic [1:0]      HDR_CTRL = 2'b01;
    localparam logic [1:0]      HDR_DATA = 2'b10;
    localparam logic [7:0]      T_REQ    = 8'h1a;
    localparam logic [7:0]      T_RESP   = 8'h1f;

    typedef enum logic {ST_GAP, ST_FRAME} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       w_type;
    logic             w_is_ctrl;
    logic             w_hdr_ok;
    logic             w_is_start;
    logic             w_is_term;

    logic [1:0]       w_push;      // [0] request queue, [1] response queue
    logic             w_err;
    logic [63:0]      w_out_data;
    logic [1:0]       w_out_hdr;

    logic [63:0]      r_out_data;
    logic [1:0]       r_out_hdr;
    logic [CNT_W-1:0] r_err_cnt;

    logic [1:0]       w_ready;
    logic [1:0]       w_valid;
    logic [63:0]      w_head [2];
    logic [CNT_W-1:0] w_drop [2];

    assign w_type     = bus.encoded_rx_data[7:0];
    assign w_is_ctrl  = (bus.encoded_rx_hdr == HDR_CTRL);
    assign w_hdr_ok   = w_is_ctrl || (bus.encoded_rx_hdr == HDR_DATA);
    assign w_is_start = (w_type == 8'h78) || (w_type == 8'h33) || (w_type == 8'h66);
    assign w_is_term  = (w_type == 8'h87) || (w_type == 8'h99) || (w_type == 8'haa) ||
                        (w_type == 8'hb4) || (w_type == 8'hcc) || (w_type == 8'hd2) ||
                        (w_type == 8'he1) || (w_type == 8'hff);

    // Frame tracker state register; reset always restarts in the gap.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_GAP;
        else       r_state <= w_state_next;
    end

    // Frame tracker transitions: only control blocks move the state.
    always_comb begin
        w_state_next = r_state;
        if (w_is_ctrl) begin
            case (r_state)
                ST_GAP:   if (w_is_start) w_state_next = ST_FRAME;
                ST_FRAME: if (w_is_term)  w_state_next = ST_GAP;
                default:  w_state_next = ST_GAP;
            endcase
        end
    end

    // Classification uses the state before this block: extract in gaps,
    // flag IPG types inside frames and any malformed sync header.
    always_comb begin
        w_push     = 2'b00;
        w_err      = 1'b0;
        w_out_data = bus.encoded_rx_data;
        w_out_hdr  = bus.encoded_rx_hdr;
        if (!w_hdr_ok) begin
            w_err = 1'b1;
        end else if (w_is_ctrl && ((w_type == T_REQ) || (w_type == T_RESP))) begin
            if (r_state == ST_GAP) begin
                w_push[0]  = (w_type == T_REQ);
                w_push[1]  = (w_type == T_RESP);
                w_out_data = IDLE_BLK;
                w_out_hdr  = HDR_CTRL;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // One-cycle registered stream path toward the decoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= IDLE_BLK;
            r_out_hdr  <= HDR_CTRL;
        end else begin
            r_out_data <= w_out_data;
            r_out_hdr  <= w_out_hdr;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (reset)                           r_err_cnt <= '0;
        else if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign w_ready = {bus.rx_resp_ready, bus.rx_req_ready};

    // Two identical FWFT queues; a push into a full queue is lost even if the
    // same cycle pops, since fullness is judged at the start of the cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_q
            logic [63:0]      r_mem [FIFO_DEPTH];
            logic [PTR_W-1:0] r_wptr;
            logic [PTR_W-1:0] r_rptr;
            logic [PTR_W:0]   r_count;
            logic [CNT_W-1:0] r_drop;
            logic             w_full;
            logic             w_nonempty;
            logic             w_wr;
            logic             w_rd;

            assign w_full     = (r_count == FULL_CNT);
            assign w_nonempty = (r_count != '0);
            assign w_wr       = w_push[gi] && !w_full;
            assign w_rd       = w_nonempty && w_ready[gi];

            // Storage write; contents need no reset since occupancy gates them.
            always_ff @(posedge clk) begin
                if (w_wr) r_mem[r_wptr] <= bus.encoded_rx_data;
            end

            // Pointers and occupancy; reset discards anything queued.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
                    if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
                    case ({w_wr, w_rd})
                        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Saturating count of pushes lost to a full queue.
            always_ff @(posedge clk) begin
                if (reset)                                   r_drop <= '0;
                else if (w_push[gi] && w_full && (r_drop != '1)) r_drop <= r_drop + 1'b1;
            end

            assign w_head[gi]  = r_mem[r_rptr];
            assign w_valid[gi] = w_nonempty;
            assign w_drop[gi]  = r_drop;
        end
    endgenerate

    assign bus.proced_encoded_rx_data = r_out_data;
    assign bus.proced_encoded_rx_hdr  = r_out_hdr;
    assign bus.rx_req_chunk           = w_head[0];
    assign bus.rx_req_valid           = w_valid[0];
    assign bus.rx_resp_chunk          = w_head[1];
    assign bus.rx_resp_valid          = w_valid[1];
    assign bus.req_drop_cnt           = w_drop[0];
    assign bus.resp_drop_cnt          = w_drop[1];
    assign bus.err_cnt                = r_err_cnt;
endmodule

// File: tb/tb_ipg_rx.sv
// Directed bench for ipg_rx: extraction, pass-through, in-frame errors,
// queue overflow, pop ordering and mid-stream reset.
module tb_ipg_rx;
    localparam logic [63:0] IDLE = 64'h000000000000001e;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ipg_rx_if #(.CNT_W(16)) bus ();

    ipg_rx #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [1:0] h);
        bus.encoded_rx_data = d;
        bus.encoded_rx_hdr  = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] d, input logic [1:0] h);
        check({tag, "_data"}, bus.proced_encoded_rx_data, d);
        check({tag, "_hdr"}, {62'd0, bus.proced_encoded_rx_hdr}, {62'd0, h});
    endtask

    function automatic logic [63:0] mk(input int i);
        return {8'hC0, 48'(i), 8'h1a};
    endfunction

    logic [63:0] blk [5];
    logic [1:0]  hdr [5];

    initial begin
        reset = 1'b1;
        drive(IDLE, 2'b01);
        bus.rx_req_ready  = 1'b0;
        bus.rx_resp_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_out("rst_out", IDLE, 2'b01);
        check("rst_req_valid", {63'd0, bus.rx_req_valid}, 64'd0);
        check("rst_resp_valid", {63'd0, bus.rx_resp_valid}, 64'd0);
        check("rst_err", {48'd0, bus.err_cnt}, 64'd0);
        check("rst_req_drop", {48'd0, bus.req_drop_cnt}, 64'd0);
        check("rst_resp_drop", {48'd0, bus.resp_drop_cnt}, 64'd0);
        $display("reset checked");

        // Single request block in the gap.
        drive(64'hA1B2C3D4E5F6071a, 2'b01);
        step();
        check_out("req1_out", IDLE, 2'b01);
        check("req1_valid", {63'd0, bus.rx_req_valid}, 64'd1);
        check("req1_chunk", bus.rx_req_chunk, 64'hA1B2C3D4E5F6071a);
        check("req1_resp_valid", {63'd0, bus.rx_resp_valid}, 64'd0);
        check("req1_err", {48'd0, bus.err_cnt}, 64'd0);
        $display("req extract chunk=%h", bus.rx_req_chunk);
        drive(IDLE, 2'b01);
        bus.rx_req_ready = 1'b1;
        step();
        bus.rx_req_ready = 1'b0;
        check("req1_popped", {63'd0, bus.rx_req_valid}, 64'd0);

        // Frame then response block in the following gap.
        blk[0] = 64'h0011223344556678; hdr[0] = 2'b01;
        blk[1] = 64'h0123456789abcdef; hdr[1] = 2'b10;
        blk[2] = 64'hfedcba9876543210; hdr[2] = 2'b10;
        blk[3] = 64'h0000000000000087; hdr[3] = 2'b01;
        blk[4] = 64'h112233445566771f; hdr[4] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            drive(blk[i], hdr[i]);
            step();
            if (i == 4) check_out("frm_resp_out", IDLE, 2'b01);
            else        check_out("frm_pass", blk[i], hdr[i]);
            $display("frame blk %0d in=%h out=%h", i, blk[i], bus.proced_encoded_rx_data);
        end
        check("frm_resp_valid", {63'd0, bus.rx_resp_valid}, 64'd1);
        check("frm_resp_chunk", bus.rx_resp_chunk, 64'h112233445566771f);
        check("frm_req_valid", {63'd0, bus.rx_req_valid}, 64'd0);
        drive(IDLE, 2'b01);
        bus.rx_resp_ready = 1'b1;
        step();
        bus.rx_resp_ready = 1'b0;
        check("frm_resp_popped", {63'd0, bus.rx_resp_valid}, 64'd0);

        // Request type inside a frame is an error and passes through.
        blk[0] = 64'h0000000000000078; hdr[0] = 2'b01;
        blk[1] = 64'hdeadbeef0000001a; hdr[1] = 2'b01;
        blk[2] = 64'h00000000000000ff; hdr[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            drive(blk[i], hdr[i]);
            step();
            check_out("inframe_pass", blk[i], hdr[i]);
            $display("inframe blk %0d out=%h", i, bus.proced_encoded_rx_data);
        end
        check("inframe_req_valid", {63'd0, bus.rx_req_valid}, 64'd0);
        check("inframe_err", {48'd0, bus.err_cnt}, 64'd1);

        // Ten requests into an 8-deep queue with no consumer.
        for (int i = 0; i < 10; i++) begin
            drive(mk(i), 2'b01);
            step();
            check_out("ovf_out", IDLE, 2'b01);
            $display("ovf push %0d drop=%0d", i, bus.req_drop_cnt);
        end
        check("ovf_drop", {48'd0, bus.req_drop_cnt}, 64'd2);
        drive(IDLE, 2'b01);
        bus.rx_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_pop_valid", {63'd0, bus.rx_req_valid}, 64'd1);
            check("ovf_pop_chunk", bus.rx_req_chunk, mk(i));
            $display("ovf pop %0d chunk=%h", i, bus.rx_req_chunk);
            step();
        end
        bus.rx_req_ready = 1'b0;
        check("ovf_empty", {63'd0, bus.rx_req_valid}, 64'd0);

        // Full queue: a push coinciding with a pop is still dropped.
        for (int i = 0; i < 8; i++) begin
            drive(mk(16 + i), 2'b01);
            step();
        end
        drive(mk(99), 2'b01);
        bus.rx_req_ready = 1'b1;
        step();
        bus.rx_req_ready = 1'b0;
        drive(IDLE, 2'b01);
        check("full_pop_drop", {48'd0, bus.req_drop_cnt}, 64'd3);
        check("full_pop_head", bus.rx_req_chunk, mk(17));
        $display("full+pop drop=%0d head=%h", bus.req_drop_cnt, bus.rx_req_chunk);
        bus.rx_req_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("full_pop_valid", {63'd0, bus.rx_req_valid}, 64'd1);
            check("full_pop_chunk", bus.rx_req_chunk, mk(17 + i));
            step();
        end
        bus.rx_req_ready = 1'b0;
        check("full_pop_empty", {63'd0, bus.rx_req_valid}, 64'd0);

        // Bad header, then reset with entries queued and a frame open.
        for (int i = 0; i < 3; i++) begin
            drive(mk(40 + i), 2'b01);
            step();
        end
        drive(64'h0000000000000078, 2'b01);
        step();
        drive(64'h0badc0de00001234, 2'b11);
        step();
        check_out("badhdr_pass", 64'h0badc0de00001234, 2'b11);
        check("badhdr_err", {48'd0, bus.err_cnt}, 64'd2);
        check("badhdr_req_valid", {63'd0, bus.rx_req_valid}, 64'd1);
        $display("bad hdr err=%0d", bus.err_cnt);
        drive(IDLE, 2'b01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("rst2_out", IDLE, 2'b01);
        check("rst2_req_valid", {63'd0, bus.rx_req_valid}, 64'd0);
        check("rst2_resp_valid", {63'd0, bus.rx_resp_valid}, 64'd0);
        check("rst2_err", {48'd0, bus.err_cnt}, 64'd0);
        check("rst2_req_drop", {48'd0, bus.req_drop_cnt}, 64'd0);
        check("rst2_resp_drop", {48'd0, bus.resp_drop_cnt}, 64'd0);
        drive(mk(50), 2'b01);
        step();
        check_out("rst2_gap_out", IDLE, 2'b01);
        check("rst2_gap_valid", {63'd0, bus.rx_req_valid}, 64'd1);
        check("rst2_gap_chunk", bus.rx_req_chunk, mk(50));
        $display("post-reset extract chunk=%h", bus.rx_req_chunk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
